// File: rtl/serial_add_pkg.sv
// serial_adder_n shared types and sizing helpers.
// State encoding plus digit-count and counter-width functions.
package serial_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int ndig_f(
    input int w,
    input int d
  );
    return w / d;
  endfunction

  function automatic int cnt_w_f(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fa_digit.sv
// DIGIT_W-bit ripple slice built from 1-bit full-adder cells.
// c_msb_in exposes the carry into the slice MSB for overflow.
module fa_digit
  import serial_add_pkg::*;
#(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout,
  output logic               c_msb_in
);

  logic [DIGIT_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i])
                  | (c[i] & (a[i] ^ b[i]));
  end

  assign cout     = c[DIGIT_W];
  assign c_msb_in = c[DIGIT_W-1];

endmodule

// File: rtl/serial_adder_n.sv
// Multi-cycle adder: one DIGIT_W slice per clock, LSB digit first.
// Define SERIAL_ADD_SUB_EN to add the sub port (A - B).
module serial_adder_n
  import serial_add_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int NDIG = ndig_f(WIDTH, DIGIT_W);
  localparam int CW   = cnt_w_f(NDIG);

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic             carry_q;

  logic [WIDTH-1:0] b_cap;
  logic             c_cap;
  logic             accept;
  logic             last;

  logic [DIGIT_W-1:0]       dsum;
  logic                     dcout;
  logic                     dcmsb;
  logic [WIDTH+DIGIT_W-1:0] r_cat;
  logic [WIDTH-1:0]         r_nx;

  fa_digit #(
    .DIGIT_W(DIGIT_W)
  ) u_fa (
    .a       (a_sh[DIGIT_W-1:0]),
    .b       (b_sh[DIGIT_W-1:0]),
    .cin     (carry_q),
    .s       (dsum),
    .cout    (dcout),
    .c_msb_in(dcmsb)
  );

`ifdef SERIAL_ADD_SUB_EN
  assign b_cap = sub ? ~b : b;
  assign c_cap = sub ? 1'b1 : cin;
`else
  assign b_cap = b;
  assign c_cap = cin;
`endif

  assign accept = start && (state_q != S_RUN);
  assign last   = (state_q == S_RUN)
               && (cnt_q == CW'(NDIG - 1));
  assign r_cat  = {dsum, r_sh};
  assign r_nx   = WIDTH'(r_cat >> DIGIT_W);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: DONE may chain straight into another RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN:  if (last)  state_d = S_DONE;
      S_DONE: state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decode directly from the state flop.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state_q == S_RUN):  busy = 1'b1;
      (state_q == S_DONE): done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture on accept, then one digit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      r_sh    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b_cap;
      carry_q <= c_cap;
      cnt_q   <= '0;
    end else if (state_q == S_RUN) begin
      a_sh    <= a_sh >> DIGIT_W;
      b_sh    <= b_sh >> DIGIT_W;
      r_sh    <= r_nx;
      carry_q <= dcout;
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  // Result registers only move on the final digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (last) begin
      s    <= r_nx;
      cout <= dcout;
      ovf  <= dcout ^ dcmsb;
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n.
// Two instances: DIGIT_W=1 (u1) and DIGIT_W=4 (u4).
module tb_serial_adder_n;

  logic       clk;
  logic       rst_n;
  logic       start1, start4;
  logic [7:0] a, b;
  logic       cin;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub;
`endif

  logic [7:0] s1, s4;
  logic       cout1, cout4;
  logic       ovf1, ovf4;
  logic       busy1, busy4;
  logic       done1, done4;

  int n_chk;
  int n_fail;

  serial_adder_n #(.WIDTH(8), .DIGIT_W(1)) u1 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start1),
    .a    (a),
    .b    (b),
    .cin  (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub  (sub),
`endif
    .s    (s1),
    .cout (cout1),
    .ovf  (ovf1),
    .busy (busy1),
    .done (done1)
  );

  serial_adder_n #(.WIDTH(8), .DIGIT_W(4)) u4 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start4),
    .a    (a),
    .b    (b),
    .cin  (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub  (sub),
`endif
    .s    (s4),
    .cout (cout4),
    .ovf  (ovf4),
    .busy (busy4),
    .done (done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op on u1 (sel=0) or u4 (sel=1); report latency,
  // busy cycles and whether s held steady before done.
  task automatic run_op(
    input  bit       sel,
    input  bit [7:0] av,
    input  bit [7:0] bv,
    input  bit       cv,
    input  bit       sv,
    output int       lat,
    output int       bcnt,
    output bit       held
  );
    logic [7:0] s0;
    s0 = sel ? s4 : s1;
    @(negedge clk);
    a   = av;
    b   = bv;
    cin = cv;
`ifdef SERIAL_ADD_SUB_EN
    sub = sv;
`else
    if (sv) $display("note: sub ignored");
`endif
    if (sel) start4 = 1'b1;
    else     start1 = 1'b1;
    lat  = -1;
    bcnt = 0;
    held = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      start4 = 1'b0;
      if (sel ? busy4 : busy1) bcnt++;
      if (sel ? done4 : done1) begin
        lat = i - 1;
        break;
      end
      if ((sel ? s4 : s1) !== s0) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({s1, cout1, ovf1, busy1, done1} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_u1 got %h/%b/%b/%b/%b want 0",
               s1, cout1, ovf1, busy1, done1);
    end
    n_chk++;
    if ({s4, cout4, ovf4, busy4, done4} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_u4 got %h/%b/%b/%b/%b want 0",
               s4, cout4, ovf4, busy4, done4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_u1 busy=%b done=%b want 0 0",
               busy1, done1);
    end
  endtask

  task automatic test_add_carry();
    int lat, bc;
    bit held;
    run_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, lat, bc, held);
    n_chk++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL ff01_lat got %0d want 8", lat);
    end
    n_chk++;
    if (bc !== 8) begin
      n_fail++;
      $display("FAIL ff01_busy got %0d want 8", bc);
    end
    n_chk++;
    if (!held) begin
      n_fail++;
      $display("FAIL ff01_hold got changed want held");
    end
    n_chk++;
    if ({s1, cout1, ovf1} !== {8'h00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL ff01_res got %h/%b/%b want 00/1/0",
               s1, cout1, ovf1);
    end
    @(negedge clk);
    n_chk++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL ff01_pulse done=%b busy=%b want 0 0",
               done1, busy1);
    end
  endtask

  task automatic test_signed_ovf();
    int lat, bc;
    bit held;
    run_op(1'b0, 8'h7F, 8'h01, 1'b1, 1'b0, lat, bc, held);
    n_chk++;
    if ({s1, cout1, ovf1} !== {8'h81, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_res got %h/%b/%b want 81/0/1",
               s1, cout1, ovf1);
    end
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (s1 !== 8'h81 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_hold got %h done=%b want 81 0",
               s1, done1);
    end
  endtask

  task automatic test_digit4();
    int lat, bc;
    bit held;
    run_op(1'b1, 8'h3C, 8'hC5, 1'b1, 1'b0, lat, bc, held);
    n_chk++;
    if (lat !== 2 || bc !== 2) begin
      n_fail++;
      $display("FAIL d4_timing got lat=%0d busy=%0d want 2 2",
               lat, bc);
    end
    n_chk++;
    if ({s4, cout4, ovf4} !== {8'h02, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL d4_res got %h/%b/%b want 02/1/0",
               s4, cout4, ovf4);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    start1 = 1'b1;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (i == 3) begin
        a = 8'h55; b = 8'h55; cin = 1'b1;
        start1 = 1'b1;
      end
      if (done1) begin
        lat = i - 1;
        break;
      end
    end
    start1 = 1'b0;
    n_chk++;
    if (lat !== 8 || s1 !== 8'h30) begin
      n_fail++;
      $display("FAIL ign_res got lat=%0d s=%h want 8 30",
               lat, s1);
    end
    @(negedge clk);
    n_chk++;
    if (busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_queue busy=%b want 0", busy1);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    bit bad;
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0;
    start1 = 1'b1;
    d1 = -1; d2 = -1; bad = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done1 && d1 < 0) begin
        d1 = i;
        n_chk++;
        if (s1 !== 8'h03) begin
          n_fail++;
          $display("FAIL b2b_first got %h want 03", s1);
        end
        a = 8'h40; b = 8'h0F; cin = 1'b1;
      end else if (done1) begin
        d2 = i;
        break;
      end else if (d1 > 0) begin
        start1 = 1'b0;
        if (!busy1 || s1 !== 8'h03) bad = 1'b1;
      end
    end
    start1 = 1'b0;
    n_chk++;
    if (d1 !== 9 || d2 !== 18) begin
      n_fail++;
      $display("FAIL b2b_timing got %0d,%0d want 9,18",
               d1, d2);
    end
    n_chk++;
    if (s1 !== 8'h50 || bad) begin
      n_fail++;
      $display("FAIL b2b_second got %h bad=%b want 50 0",
               s1, bad);
    end
  endtask

  task automatic test_abort();
    bit seen;
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({s1, cout1, ovf1, busy1, done1} !== 12'h0) begin
      n_fail++;
      $display("FAIL abort got %h/%b/%b/%b/%b want 0",
               s1, cout1, ovf1, busy1, done1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done1 || busy1) seen = 1'b1;
    end
    n_chk++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort_quiet got activity want none");
    end
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    int lat, bc;
    bit held;
    run_op(1'b0, 8'h05, 8'h07, 1'b0, 1'b1, lat, bc, held);
    n_chk++;
    if ({s1, cout1, ovf1} !== {8'hFE, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sub1 got %h/%b/%b want FE/0/0",
               s1, cout1, ovf1);
    end
    run_op(1'b0, 8'h80, 8'h01, 1'b0, 1'b1, lat, bc, held);
    n_chk++;
    if ({s1, cout1, ovf1} !== {8'h7F, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL sub2 got %h/%b/%b want 7F/1/1",
               s1, cout1, ovf1);
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    n_chk  = 0;
    n_fail = 0;
    start1 = 1'b0;
    start4 = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub    = 1'b0;
`endif
    test_reset();
    test_add_carry();
    test_signed_ovf();
    test_digit4();
    test_ignore_start();
    test_back_to_back();
    test_abort();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_n.md
# serial_adder_n

Parametrised multi-cycle adder. It computes A + B + CIN over WIDTH bits by iterating one DIGIT_W-bit ripple adder slice per clock, LSB digit first. It replaces the single-bit combinational full adder wherever area matters more than latency. It uses a START/BUSY/DONE handshake and holds its registered result until the next operation completes.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- DIGIT_W, 1, bits added per cycle; must divide WIDTH evenly. NDIG = WIDTH/DIGIT_W.
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- START  in  1  request; sampled only when not BUSY.
- A  in  WIDTH  operand A, captured on an accepted START.
- B  in  WIDTH  operand B, captured on an accepted START.
- CIN  in  1  carry-in, captured on an accepted START.
- SUB  in  1  subtract select, captured on an accepted START (present only with SERIAL_ADD_SUB_EN).
- S  out  WIDTH  registered sum.
- COUT  out  1  registered carry-out of the MSB.
- OVF  out  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- BUSY  out  1  high while state is RUN.
- DONE  out  1  one-cycle pulse; the result was updated at this edge.

## Operation
- States:
  - IDLE: the reset state.
  - RUN: one digit is added per cycle; a digit counter runs 0..NDIG-1.
  - DONE: lasts one cycle.
- Transitions:
  - IDLE → RUN when START=1.
  - RUN → DONE when the counter reaches NDIG-1.
  - DONE → RUN if START=1; otherwise DONE → IDLE.
- Accepted START (state IDLE or DONE):
  - Latches A and B into internal shift registers and CIN into the running-carry flop.
  - Clears the counter.
- Each RUN cycle:
  - The slice adds the low DIGIT_W bits of A_sh and B_sh plus the carry.
  - The sum digit shifts into the top of a result shift register; A_sh and B_sh shift right by DIGIT_W.
  - The carry flop takes the slice carry-out.
- Final digit:
  - S, COUT and OVF load from the completed result at the same edge.
  - Until then they hold their previous values. Intermediate digits are never visible on S.
- START while in RUN is ignored. It is not queued.
- Arithmetic is modulo 2^WIDTH. COUT is the true carry out of bit WIDTH-1.
- Reset mid-operation aborts the operation immediately. No DONE is produced.
- Reset values: S=0, COUT=0, OVF=0, BUSY=0, DONE=0, state IDLE, counter 0, shift and carry registers 0.

## Timing
- START high at edge k (accepted): BUSY=1 from edge k to edge k+NDIG.
- S, COUT, OVF and DONE update at edge k+NDIG. DONE=1 for exactly one cycle.
- Latency is NDIG cycles from accepting edge to result. Throughput is one result per NDIG cycles.
- Back-to-back: START held high through DONE is accepted at edge k+NDIG+1. The result of the next operation lands at edge k+2·NDIG+1.
- RST_N falling edge forces all outputs to reset values without waiting for CLK. The first START is sampled at the first CLK edge after RST_N rises.
- DIGIT_W=WIDTH gives NDIG=1: one RUN cycle, result at edge k+1.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - The SUB port exists.
  - When SUB is captured as 1, B is inverted on capture and CIN is ignored; the carry flop is forced to 1. The block computes A − B.
  - COUT=1 means no borrow. OVF is the signed subtract overflow.
- SERIAL_ADD_SUB_EN undefined: no SUB port, add only, no inverter logic.

## Structure
- Package serial_add_pkg holds:
  - the state typedef (S_IDLE, S_RUN, S_DONE);
  - a function computing NDIG;
  - the counter width as ceil(log2(NDIG)), minimum 1.
- Sub-module fa_digit: combinational DIGIT_W-bit ripple of 1-bit full-adder cells. Ports A, B, CIN, S, COUT, plus C_MSB_IN (carry into the slice MSB) for OVF.
- Top level holds the FSM, counter, shift registers, carry flop and output registers.

## Test plan
- WIDTH=8, DIGIT_W=1: A=8'hFF, B=8'h01, CIN=0 → after 8 cycles S=8'h00, COUT=1, OVF=0, DONE pulses once.
- WIDTH=8, DIGIT_W=1: A=8'h7F, B=8'h01, CIN=1 → S=8'h81, COUT=0, OVF=1. S holds 8'h81 after DONE falls.
- WIDTH=8, DIGIT_W=4: A=8'h3C, B=8'hC5, CIN=1 → S=8'h02, COUT=1, DONE at edge k+2, BUSY high for 2 cycles.
- START pulsed during RUN with different operands → ignored; the first result is unchanged. START held through DONE → second result at edge k+2·NDIG+1.
- RST_N driven low at cycle 3 of a WIDTH=8, DIGIT_W=1 run → S, COUT, OVF, BUSY, DONE all 0 immediately; no DONE pulse follows.
- With SERIAL_ADD_SUB_EN: A=8'h05, B=8'h07, SUB=1 → S=8'hFE, COUT=0, OVF=0. A=8'h80, B=8'h01, SUB=1 → S=8'h7F, COUT=1, OVF=1.
